// File: rtl/opto_cycle_reader_pkg.sv
// Shared constants and FSM encoding for the opto-cycle statistics readout.
package opto_cycle_reader_pkg;

  localparam logic [5:0]  ADDR_HDR  = 6'd0;
  localparam logic [5:0]  ADDR_ZERO = 6'd63;
  localparam int unsigned MAX_SLOTS = 62;
  localparam int unsigned SUM_W     = 38;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_PUSH,
    ST_DONE
  } state_t;

endpackage

// File: rtl/opto_cycle_reader_stat_acc.sv
// Running min/max/sum of slot periods; cleared at pass start, updated per slot word.
module cycle_stat_acc
  import opto_cycle_reader_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             update,
  input  logic [31:0]      value,
  output logic [31:0]      min_val,
  output logic [31:0]      max_val,
  output logic [SUM_W-1:0] sum_val
);

  // Accumulators: clear has priority over update; unsigned compares throughout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_val <= '0;
      max_val <= '0;
      sum_val <= '0;
    end else if (clear) begin
      min_val <= '1;
      max_val <= '0;
      sum_val <= '0;
    end else if (update) begin
      if (value < min_val) min_val <= value;
      if (value > max_val) max_val <= value;
      sum_val <= sum_val + {{(SUM_W-32){1'b0}}, value};
    end
  end

endmodule

// File: rtl/opto_cycle_reader.sv
// Scans the opto-cycle RAM (header, slot periods, zero-to-zero period), streams the
// record over valid/ready and publishes slot-period statistics at the end of each pass.
module opto_cycle_reader #(
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned MAX_SLOTS = opto_cycle_reader_pkg::MAX_SLOTS
) (
  input  logic        i_clk_50m,
  input  logic        i_rst_n,
  input  logic        i_start,
  output logic        o_busy,
  output logic [5:0]  o_ram_raddr,
  output logic        o_ram_ren,
  input  logic [31:0] i_ram_rdata,
  output logic [31:0] o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_tx_last,
  output logic [7:0]  o_opto_num,
  output logic [31:0] o_period_min,
  output logic [31:0] o_period_max,
  output logic [37:0] o_period_sum,
  output logic        o_stat_valid,
  output logic        o_err
);

  import opto_cycle_reader_pkg::*;

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  state_t             state, state_nx;
  logic [5:0]         addr;
  logic [7:0]         n_eff;
  logic [1:0]         lat_cnt;
  logic               start_acc, capture, hs;
  logic               hdr_bad, is_slot;
  logic [31:0]        acc_min, acc_max;
  logic [SUM_W-1:0]   acc_sum;

  assign o_ram_raddr = addr;
  assign is_slot     = (addr != ADDR_HDR) && (addr != ADDR_ZERO);
  assign hdr_bad     = (o_tx_data[31:8] != '0) || (o_tx_data[7:0] == '0) ||
                       ({24'd0, o_tx_data[7:0]} > MAX_SLOTS);

  cycle_stat_acc u_acc (
    .clk     (i_clk_50m),
    .rst_n   (i_rst_n),
    .clear   (start_acc),
    .update  (capture && is_slot),
    .value   (i_ram_rdata),
    .min_val (acc_min),
    .max_val (acc_max),
    .sum_val (acc_sum)
  );

  // State register.
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // Next-state logic and single-cycle strobes.
  always_comb begin
    state_nx     = state;
    start_acc    = 1'b0;
    capture      = 1'b0;
    hs           = 1'b0;
    o_ram_ren    = 1'b0;
    o_stat_valid = 1'b0;
    case (state)
      ST_IDLE: if (i_start) begin
        start_acc = 1'b1;
        state_nx  = ST_READ;
      end
      ST_READ: begin
        o_ram_ren = 1'b1;
        state_nx  = ST_WAIT;
      end
      ST_WAIT: if (lat_cnt == LAT_LAST) begin
        capture  = 1'b1;
        state_nx = ST_PUSH;
      end
      ST_PUSH: if (i_tx_ready) begin
        hs       = 1'b1;
        state_nx = (addr == ADDR_ZERO) ? ST_DONE : ST_READ;
      end
      ST_DONE: begin
        o_stat_valid = 1'b1;
        state_nx     = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Datapath: address walk, stream register, header decode and stat publication.
  // Stats are registered on the final handshake so they are already stable
  // during the DONE cycle that carries o_stat_valid.
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr         <= '0;
      n_eff        <= '0;
      lat_cnt      <= '0;
      o_busy       <= 1'b0;
      o_err        <= 1'b0;
      o_tx_data    <= '0;
      o_tx_valid   <= 1'b0;
      o_tx_last    <= 1'b0;
      o_opto_num   <= '0;
      o_period_min <= '0;
      o_period_max <= '0;
      o_period_sum <= '0;
    end else begin
      if (state == ST_READ)      lat_cnt <= '0;
      else if (state == ST_WAIT) lat_cnt <= lat_cnt + 2'd1;

      if (start_acc) begin
        o_busy <= 1'b1;
        o_err  <= 1'b0;
        addr   <= ADDR_HDR;
        n_eff  <= '0;
      end

      if (capture) begin
        o_tx_data  <= i_ram_rdata;
        o_tx_valid <= 1'b1;
        o_tx_last  <= (addr == ADDR_ZERO);
      end

      if (hs) begin
        o_tx_valid <= 1'b0;
        o_tx_last  <= 1'b0;
        if (addr == ADDR_HDR) begin
          if (hdr_bad) begin
            o_err <= 1'b1;
            n_eff <= '0;
            addr  <= ADDR_ZERO;
          end else begin
            n_eff <= o_tx_data[7:0];
            addr  <= 6'd1;
          end
        end else if (addr == ADDR_ZERO) begin
          o_opto_num   <= n_eff;
          o_period_min <= (n_eff == '0) ? '0 : acc_min;
          o_period_max <= acc_max;
          o_period_sum <= acc_sum;
        end else begin
          addr <= (addr == n_eff[5:0]) ? ADDR_ZERO : addr + 6'd1;
        end
      end

      if (state == ST_DONE) o_busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_opto_cycle_reader.sv
// Scoreboard bench: expected records are queued when a pass is started and a
// negedge monitor pops and compares every handshaken word and every stat pulse.
module tb_opto_cycle_reader;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        ready = 1'b1;
  logic        busy, ren, tx_valid, tx_last, stat_valid, err;
  logic [5:0]  raddr;
  logic [31:0] rdata, tx_data, pmin, pmax;
  logic [7:0]  opto_num;
  logic [37:0] psum;

  always #10 clk = ~clk;

  opto_cycle_reader #(.RD_LAT(LAT), .MAX_SLOTS(62)) dut (
    .i_clk_50m(clk), .i_rst_n(rst_n), .i_start(start), .o_busy(busy),
    .o_ram_raddr(raddr), .o_ram_ren(ren), .i_ram_rdata(rdata),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(ready),
    .o_tx_last(tx_last), .o_opto_num(opto_num), .o_period_min(pmin),
    .o_period_max(pmax), .o_period_sum(psum), .o_stat_valid(stat_valid),
    .o_err(err)
  );

  // RAM model with LAT-cycle read latency.
  logic [31:0] mem [64];
  logic [31:0] pipe [3];
  always @(posedge clk) begin
    pipe[0] <= ren ? mem[raddr] : 32'hDEAD_BEEF;
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end
  assign rdata = pipe[LAT-1];

  typedef struct {
    logic [7:0]  num;
    logic [31:0] mn;
    logic [31:0] mx;
    logic [37:0] sm;
    logic        err;
  } stat_t;

  logic [32:0] word_q [$];
  stat_t       stat_q [$];
  int          checks = 0;
  int          failures = 0;
  int          ready_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: record = header, N valid slots, zero-to-zero word; stats over slots.
  task automatic expect_pass();
    logic [7:0]  n;
    bit          ok;
    int unsigned ne;
    stat_t       s;
    n  = mem[0][7:0];
    ok = (mem[0][31:8] == 24'd0) && (n >= 1) && (n <= 62);
    ne = ok ? n : 0;
    s.num = 8'(ne);
    s.mn  = 32'hFFFF_FFFF;
    s.mx  = 32'd0;
    s.sm  = 38'd0;
    s.err = !ok;
    word_q.push_back({1'b0, mem[0]});
    for (int unsigned i = 1; i <= ne; i++) begin
      word_q.push_back({1'b0, mem[i]});
      if (mem[i] < s.mn) s.mn = mem[i];
      if (mem[i] > s.mx) s.mx = mem[i];
      s.sm = s.sm + 38'(mem[i]);
    end
    word_q.push_back({1'b1, mem[63]});
    if (ne == 0) s.mn = 32'd0;
    stat_q.push_back(s);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
  endtask

  task automatic load_plan();
    fill_random();
    mem[0] = 5; mem[1] = 100; mem[2] = 200; mem[3] = 50; mem[4] = 300; mem[5] = 150;
    mem[63] = 800;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx"},    {31'd0, tx_valid, tx_last, tx_data}, 64'd0);
    check({tag, "_ctrl"},  {54'd0, busy, ren, raddr, stat_valid, err}, 64'd0);
    check({tag, "_minmax"}, {pmin, pmax}, 64'd0);
    check({tag, "_sum"},   {18'd0, opto_num, psum}, 64'd0);
  endtask

  task automatic run_pass(input bit poke_busy);
    int c;
    expect_pass();
    pulse_start();
    if (poke_busy) begin
      repeat (4) @(posedge clk);
      #1 check("busy_at_poke", {63'd0, busy}, 64'd1);
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    c = 0;
    while (stat_q.size() != 0 && c < 3000) begin
      @(posedge clk);
      c++;
    end
    if (stat_q.size() != 0) begin
      check("pass_timeout", 64'(stat_q.size()), 64'd0);
      stat_q.delete();
    end
    check("words_drained", 64'(word_q.size()), 64'd0);
    word_q.delete();
    repeat (3) @(posedge clk);
  endtask

  // Downstream ready: tied high, or low on roughly one cycle in three.
  initial begin
    forever begin
      @(posedge clk); #1;
      ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: word handshakes, stall stability, stat pulses.
  initial begin
    logic [32:0] prev_word, exp_w;
    bit          prev_stall;
    stat_t       s;
    prev_stall = 0;
    prev_word  = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_stall) check("stall_hold", {31'd0, tx_valid, tx_last, tx_data}, {31'd0, 1'b1, prev_word});
        if (tx_valid && ready) begin
          if (word_q.size() == 0) check("unexpected_word", {31'd0, tx_last, tx_data}, 64'hFFFF_FFFF_FFFF_FFFF);
          else begin
            exp_w = word_q.pop_front();
            check("word", {31'd0, tx_last, tx_data}, {31'd0, exp_w});
          end
        end
        if (stat_valid) begin
          if (stat_q.size() == 0) check("unexpected_stat", 64'd1, 64'd0);
          else begin
            s = stat_q.pop_front();
            check("opto_num", {56'd0, opto_num}, {56'd0, s.num});
            check("min",      {32'd0, pmin},     {32'd0, s.mn});
            check("max",      {32'd0, pmax},     {32'd0, s.mx});
            check("sum",      {26'd0, psum},     {26'd0, s.sm});
            check("err",      {63'd0, err},      {63'd0, s.err});
            check("busy_in_done", {63'd0, busy}, 64'd1);
          end
        end
      end
      prev_stall = rst_n && tx_valid && !ready;
      prev_word  = {tx_last, tx_data};
    end
  end

  initial begin
    int c;
    fill_random();
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    load_plan();
    run_pass(1'b0);
    ready_mode = 1;
    run_pass(1'b1);
    ready_mode = 0;

    fill_random(); mem[0] = 0; mem[63] = 1234;
    run_pass(1'b0);
    fill_random(); mem[0] = 63; mem[63] = 1234;
    run_pass(1'b0);
    fill_random(); mem[0] = 32'h0000_0105; mem[63] = 1234;
    run_pass(1'b0);
    check("err_holds_idle", {63'd0, err}, 64'd1);

    for (int i = 1; i <= 62; i++) mem[i] = 32'hFFFF_FFFF;
    mem[0] = 62; mem[63] = 7;
    run_pass(1'b0);

    // Reset while word 3 is presented.
    load_plan();
    expect_pass();
    pulse_start();
    c = 0;
    while (word_q.size() > 5 && c < 500) begin @(posedge clk); c++; end
    #1;
    while (!tx_valid && c < 500) begin @(posedge clk); #1; c++; end
    check("reach_word3", {63'd0, tx_valid}, 64'd1);
    rst_n = 1'b0;
    #1 check_all_zero("midpass_reset");
    word_q.delete();
    stat_q.delete();
    repeat (3) begin
      @(posedge clk); #1;
      check("no_stat_in_reset", {62'd0, stat_valid, busy}, 64'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    load_plan();
    run_pass(1'b1);

    for (int t = 0; t < 6; t++) begin
      fill_random();
      mem[0] = (t == 5) ? 32'd70 : 32'($urandom_range(1, 62));
      if (t == 2) for (int i = 1; i < 63; i++) mem[i] = $urandom_range(0, 1000);
      ready_mode = t % 2;
      run_pass(t == 3);
    end
    ready_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
